// File: rtl/pc_fetch_seq.sv
// rtl/pc_fetch_seq.sv - multi-program PC/fetch sequencer with branch, call/return stack and stall
// Optional cycle counter output is enabled by defining PC_FETCH_CYCLE_CNT_EN.
module pc_fetch_seq #(
    parameter int PC_W      = 10,
    parameter int NUM_PROGS = 4,
    parameter int SEL_W     = 2,
    parameter int RAS_DEPTH = 4
) (
    input  logic                      CLK,
    input  logic                      Init_n,
    input  logic                      Start,
    input  logic [SEL_W-1:0]          ProgSel,
    input  logic [NUM_PROGS*PC_W-1:0] Prog_start,
    input  logic [NUM_PROGS*PC_W-1:0] Prog_end,
    input  logic                      Stall,
    input  logic                      Branch_en,
    input  logic                      Flag_in,
    input  logic                      Branch_rel,
    input  logic [PC_W-1:0]           Target,
    input  logic                      Call_en,
    input  logic                      Ret_en,
    output logic [PC_W-1:0]           PC,
    output logic                      Halt,
    output logic                      Busy,
`ifdef PC_FETCH_CYCLE_CNT_EN
    output logic [31:0]               Cycle_cnt,
`endif
    output logic                      Ras_err
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

    state_t            state, state_nxt;
    logic [PC_W-1:0]   pc_nxt, end_addr, end_nxt, pc_inc;
    logic [PC_W-1:0]   sel_start, sel_end;
    logic [PTR_W-1:0]  wp, wp_nxt, top_idx;
    logic [CNT_W-1:0]  ras_cnt, ras_cnt_nxt;
    logic              ras_err_nxt, push;
    logic [PC_W-1:0]   ras_mem [RAS_DEPTH];

    assign pc_inc  = PC + 1'b1;
    assign top_idx = wp - 1'b1;

    always_comb begin
        sel_start = '0;
        sel_end   = '0;
        for (int i = 0; i < NUM_PROGS; i++) begin
            if (ProgSel == SEL_W'(i)) begin
                sel_start = Prog_start[i*PC_W +: PC_W];
                sel_end   = Prog_end[i*PC_W +: PC_W];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = PC;
        end_nxt     = end_addr;
        wp_nxt      = wp;
        ras_cnt_nxt = ras_cnt;
        ras_err_nxt = Ras_err;
        push        = 1'b0;
        case (state)
            S_IDLE, S_HALTED: begin
                if (Start) begin
                    pc_nxt      = sel_start;
                    end_nxt     = sel_end;
                    state_nxt   = S_RUN;
                    wp_nxt      = '0;
                    ras_cnt_nxt = '0;
                    ras_err_nxt = 1'b0;
                end
            end
            S_RUN: begin
                if (Stall) begin
                    pc_nxt = PC;
                end else if (Ret_en) begin
                    if (ras_cnt != '0) begin
                        pc_nxt      = ras_mem[top_idx];
                        wp_nxt      = top_idx;
                        ras_cnt_nxt = ras_cnt - 1'b1;
                    end else begin
                        pc_nxt      = pc_inc;
                        ras_err_nxt = 1'b1;
                    end
                end else if (Branch_en && Flag_in) begin
                    pc_nxt = Branch_rel ? PC + Target : Target;
                end else if (Call_en) begin
                    // Full stack overwrites its oldest slot: the write pointer simply wraps.
                    push   = 1'b1;
                    pc_nxt = Target;
                    wp_nxt = wp + 1'b1;
                    if (ras_cnt == CNT_W'(RAS_DEPTH)) begin
                        ras_err_nxt = 1'b1;
                    end else begin
                        ras_cnt_nxt = ras_cnt + 1'b1;
                    end
                end else if (PC == end_addr) begin
                    pc_nxt    = pc_inc;
                    state_nxt = S_HALTED;
                end else begin
                    pc_nxt = pc_inc;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Init_n) begin
        if (!Init_n) begin
            state    <= S_IDLE;
            PC       <= '0;
            end_addr <= '0;
            wp       <= '0;
            ras_cnt  <= '0;
            Ras_err  <= 1'b0;
            Halt     <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            PC       <= pc_nxt;
            end_addr <= end_nxt;
            wp       <= wp_nxt;
            ras_cnt  <= ras_cnt_nxt;
            Ras_err  <= ras_err_nxt;
            Halt     <= (state_nxt == S_HALTED);
            Busy     <= (state_nxt == S_RUN);
        end
    end

    // Stack contents need no reset; validity is tracked by ras_cnt.
    always_ff @(posedge CLK) begin
        if (push) begin
            ras_mem[wp] <= pc_inc;
        end
    end

`ifdef PC_FETCH_CYCLE_CNT_EN
    logic [31:0] cyc_cnt;

    always_ff @(posedge CLK or negedge Init_n) begin
        if (!Init_n) begin
            cyc_cnt <= '0;
        end else if (state == S_RUN) begin
            if (cyc_cnt != '1) begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
        end else if (Start) begin
            cyc_cnt <= '0;
        end
    end

    assign Cycle_cnt = cyc_cnt;
`endif

endmodule
